// File: rtl/ej32_mem_arb.sv
// eJ32 SRAM bus arbiter: core byte port (default priority) vs. host word port split
// into four big-endian byte cycles with a bounded wait. Optional c_lock: EJ32_ARB_LOCK_EN.
module ej32_mem_arb #(
  parameter int ASZ      = 17,
  parameter int DSZ      = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef EJ32_ARB_LOCK_EN
  input  logic           c_lock,
`endif
  input  logic           c_req,
  input  logic           c_we,
  input  logic [ASZ-1:0] c_addr,
  input  logic [7:0]     c_wdata,
  output logic           c_gnt,
  output logic [7:0]     c_rdata,
  output logic           stall,
  input  logic           h_req,
  input  logic           h_we,
  input  logic [ASZ-1:0] h_addr,
  input  logic [DSZ-1:0] h_wdata,
  output logic           h_ack,
  output logic [DSZ-1:0] h_rdata,
  output logic [ASZ-1:0] m_addr,
  output logic           m_we,
  output logic [7:0]     m_wdata,
  input  logic [7:0]     m_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {CORE, HOST} state_t;

  state_t          state, state_nx;
  logic [1:0]      cnt;
  logic [WW-1:0]   wait_cnt;
  logic            lock;
  logic            at_max;
  logic            takeover;
  logic            blocked;

  // Byte idx 0 is the most significant byte of the word.
  function automatic logic [7:0] get_byte(input logic [DSZ-1:0] w, input logic [1:0] idx);
    return w[DSZ-1-8*int'(idx) -: 8];
  endfunction

  function automatic logic [DSZ-1:0] put_byte(input logic [DSZ-1:0] w, input logic [1:0] idx,
                                              input logic [7:0] b);
    logic [DSZ-1:0] r;
    r = w;
    r[DSZ-1-8*int'(idx) -: 8] = b;
    return r;
  endfunction

  function automatic logic [WW-1:0] sat_inc(input logic [WW-1:0] v);
    return (v == WW'(MAX_WAIT)) ? v : v + WW'(1);
  endfunction

`ifdef EJ32_ARB_LOCK_EN
  assign lock = c_lock;
`else
  assign lock = 1'b0;
`endif

  // h_ack masks h_req so a request still high in the ack cycle starts nothing.
  assign at_max   = (wait_cnt == WW'(MAX_WAIT));
  assign takeover = (state == CORE) && h_req && !h_ack && (!c_req || at_max) && !lock;
  assign blocked  = (state == CORE) && h_req && c_req && !takeover;

  assign c_rdata = m_rdata;
  assign stall   = c_req && !c_gnt;

  always_comb begin
    state_nx = state;
    c_gnt    = 1'b0;
    m_addr   = c_addr;
    m_we     = 1'b0;
    m_wdata  = c_wdata;
    case (state)
      CORE: begin
        c_gnt = c_req;
        m_we  = c_we && c_req;
        if (takeover) state_nx = HOST;
      end
      HOST: begin
        m_addr  = h_addr + ASZ'(cnt);
        m_we    = h_we;
        m_wdata = get_byte(h_wdata, cnt);
        if (cnt == 2'd3) state_nx = CORE;
      end
      default: state_nx = CORE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CORE;
      cnt      <= 2'd0;
      wait_cnt <= '0;
      h_ack    <= 1'b0;
      h_rdata  <= '0;
    end else begin
      state <= state_nx;
      h_ack <= (state == HOST) && (cnt == 2'd3);
      if (takeover) begin
        cnt      <= 2'd0;
        wait_cnt <= '0;
      end else if (blocked) begin
        wait_cnt <= sat_inc(wait_cnt);
      end
      if (state == HOST) begin
        cnt <= cnt + 2'd1;
        if (!h_we) h_rdata <= put_byte(h_rdata, cnt, m_rdata);
      end
    end
  end

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Directed bench for ej32_mem_arb with a negedge-write SRAM model on the byte bus.
module tb_ej32_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [16:0] c_addr = '0;
  logic [7:0]  c_wdata = '0;
  logic        c_gnt, stall;
  logic [7:0]  c_rdata;
  logic        h_req = 1'b0, h_we = 1'b0;
  logic [16:0] h_addr = '0;
  logic [31:0] h_wdata = '0;
  logic        h_ack;
  logic [31:0] h_rdata;
  logic [16:0] m_addr;
  logic        m_we;
  logic [7:0]  m_wdata, m_rdata;
`ifdef EJ32_ARB_LOCK_EN
  logic        c_lock = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:(1<<17)-1];

  always #5 clk = ~clk;

  always @(negedge clk) if (m_we) mem[m_addr] <= m_wdata;
  assign m_rdata = mem[m_addr];

  ej32_mem_arb dut (
    .clk(clk), .rst_n(rst_n),
`ifdef EJ32_ARB_LOCK_EN
    .c_lock(c_lock),
`endif
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rdata(c_rdata), .stall(stall),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_rdata(h_rdata),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  typedef struct {
    logic        cr, cwe;
    logic [16:0] caddr;
    logic [7:0]  cwd;
    logic        hr, hwe;
    logic [16:0] haddr;
    logic [31:0] hwd;
    logic        e_gnt, e_stall, e_we, e_ack;
    logic [16:0] e_addr;
    logic [7:0]  e_wd;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    c_req = 0; c_we = 0; h_req = 0; h_we = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Caller is just past an edge with c_req low; returns in the ack cycle with h_req dropped.
  task automatic host_op(input logic we, input logic [16:0] a, input logic [31:0] d,
                         output int lat);
    h_req = 1; h_we = we; h_addr = a; h_wdata = d; lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (h_ack) begin
        lat = i;
        break;
      end
    end
    h_req = 0;
  endtask

  int lat;

  initial begin
    //           cr cwe caddr     cwd    hr hwe haddr     hwd            gnt st we ack addr      wd
    vt[0] = '{1, 1, 17'h00010, 8'h5A, 0, 0, 17'h0,    32'h0,         1, 0, 1, 0, 17'h00010, 8'h5A};
    vt[1] = '{1, 0, 17'h00020, 8'h11, 0, 0, 17'h0,    32'h0,         1, 0, 0, 0, 17'h00020, 8'h11};
    vt[2] = '{0, 1, 17'h00030, 8'h22, 0, 0, 17'h0,    32'h0,         0, 0, 0, 0, 17'h00030, 8'h22};
    vt[3] = '{0, 0, 17'h00040, 8'h33, 1, 1, 17'h1000, 32'hDEADBEEF,  0, 0, 0, 0, 17'h00040, 8'h33};
    vt[4] = '{0, 0, 17'h00040, 8'h33, 1, 1, 17'h1000, 32'hDEADBEEF,  0, 0, 1, 0, 17'h01000, 8'hDE};
    vt[5] = '{1, 1, 17'h00040, 8'h33, 1, 1, 17'h1000, 32'hDEADBEEF,  0, 1, 1, 0, 17'h01001, 8'hAD};
    vt[6] = '{1, 1, 17'h00040, 8'h33, 1, 1, 17'h1000, 32'hDEADBEEF,  0, 1, 1, 0, 17'h01002, 8'hBE};
    vt[7] = '{0, 0, 17'h00040, 8'h33, 1, 1, 17'h1000, 32'hDEADBEEF,  0, 0, 1, 0, 17'h01003, 8'hEF};
    vt[8] = '{1, 0, 17'h00050, 8'h00, 1, 1, 17'h1000, 32'hDEADBEEF,  1, 0, 0, 1, 17'h00050, 8'h00};
    vt[9] = '{0, 0, 17'h00060, 8'h44, 0, 1, 17'h1000, 32'hDEADBEEF,  0, 0, 0, 0, 17'h00060, 8'h44};

    // Reset state
    c_addr = 17'h00123;
    do_reset();
    #1;
    chk("rst_m_addr", 32'(m_addr), 32'h123);
    chk("rst_m_we", 32'(m_we), 0);
    chk("rst_h_ack", 32'(h_ack), 0);
    chk("rst_h_rdata", h_rdata, 32'h0);
    chk("rst_c_gnt", 32'(c_gnt), 0);

    // Table: core pass-through, then a host write with the core idle
    for (int i = 0; i < 10; i++) begin
      c_req = vt[i].cr; c_we = vt[i].cwe; c_addr = vt[i].caddr; c_wdata = vt[i].cwd;
      h_req = vt[i].hr; h_we = vt[i].hwe; h_addr = vt[i].haddr; h_wdata = vt[i].hwd;
      #1;
      chk($sformatf("v%0d_c_gnt", i), 32'(c_gnt), 32'(vt[i].e_gnt));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vt[i].e_stall));
      chk($sformatf("v%0d_m_we", i), 32'(m_we), 32'(vt[i].e_we));
      chk($sformatf("v%0d_h_ack", i), 32'(h_ack), 32'(vt[i].e_ack));
      chk($sformatf("v%0d_m_addr", i), 32'(m_addr), 32'(vt[i].e_addr));
      chk($sformatf("v%0d_m_wdata", i), 32'(m_wdata), 32'(vt[i].e_wd));
      tick();
    end
    chk("mem_10", 32'(mem[17'h00010]), 32'h5A);
    chk("mem_1000", 32'(mem[17'h01000]), 32'hDE);
    chk("mem_1001", 32'(mem[17'h01001]), 32'hAD);
    chk("mem_1002", 32'(mem[17'h01002]), 32'hBE);
    chk("mem_1003", 32'(mem[17'h01003]), 32'hEF);

    // Host read of a word laid down by a host write
    do_reset();
    h_req = 0; c_req = 0; c_addr = 17'h0;
    host_op(1'b1, 17'h1400, 32'h11223344, lat);
    chk("wr1400_latency", lat, 5);
    tick();
    host_op(1'b0, 17'h1400, 32'h0, lat);
    chk("rd_latency", lat, 5);
    chk("rd_h_rdata", h_rdata, 32'h11223344);
    c_addr = 17'h01402;
    #1;
    chk("c_rdata_pass", 32'(c_rdata), 32'h33);
    tick();
    chk("rd_ack_pulse", 32'(h_ack), 0);
    chk("rd_hold", h_rdata, 32'h11223344);

    // Starvation bound under continuous core traffic
    do_reset();
    c_req = 1; c_we = 0; c_addr = 17'h00070;
    h_req = 1; h_we = 0; h_addr = 17'h02000;
    for (int k = 0; k <= 8; k++) begin
      #1;
      chk($sformatf("starve_gnt_c%0d", k), 32'(c_gnt), 1);
      tick();
    end
    for (int k = 9; k <= 12; k++) begin
      #1;
      chk($sformatf("starve_stall_c%0d", k), 32'({c_gnt, stall}), 32'b01);
      tick();
    end
    h_req = 0;
    #1;
    chk("starve_ack_c13", 32'(h_ack), 1);
    chk("starve_regrant_c13", 32'(c_gnt), 1);
    tick();
    c_req = 0;

    // Address wrap at the top of the SRAM
    do_reset();
    host_op(1'b1, 17'h1FFFE, 32'hCAFEF00D, lat);
    chk("wrap_latency", lat, 5);
    tick();
    chk("wrap_1fffe", 32'(mem[17'h1FFFE]), 32'hCA);
    chk("wrap_1ffff", 32'(mem[17'h1FFFF]), 32'hFE);
    chk("wrap_00000", 32'(mem[17'h00000]), 32'hF0);
    chk("wrap_00001", 32'(mem[17'h00001]), 32'h0D);

    // Reset in the middle of a host write
    do_reset();
    host_op(1'b1, 17'h3000, 32'h77777777, lat);
    tick();
    h_req = 1; h_we = 1; h_addr = 17'h3000; h_wdata = 32'h01020304;
    repeat (3) tick();
    c_req = 1; c_we = 0; c_addr = 17'h00044;
    #1;
    chk("mid_cnt2_addr", 32'(m_addr), 32'h3002);
    rst_n = 0;
    #1;
    chk("mid_rst_ack", 32'(h_ack), 0);
    chk("mid_rst_m_we", 32'(m_we), 0);
    chk("mid_rst_gnt", 32'(c_gnt), 1);
    chk("mid_rst_addr", 32'(m_addr), 32'h44);
    h_req = 0;
    repeat (2) tick();
    rst_n = 1;
    c_req = 0;
    #1;
    chk("post_rst_gnt0", 32'(c_gnt), 0);
    c_req = 1;
    #1;
    chk("post_rst_gnt1", 32'(c_gnt), 1);
    repeat (3) tick();
    chk("post_rst_no_ack", 32'(h_ack), 0);
    c_req = 0;
    chk("mid_3000", 32'(mem[17'h3000]), 32'h01);
    chk("mid_3001", 32'(mem[17'h3001]), 32'h02);
    chk("mid_3002", 32'(mem[17'h3002]), 32'h77);
    chk("mid_3003", 32'(mem[17'h3003]), 32'h77);

`ifdef EJ32_ARB_LOCK_EN
    // Locked core sequence holds off a saturated host request
    do_reset();
    c_req = 1; c_lock = 1; c_addr = 17'h00080;
    h_req = 1; h_we = 0; h_addr = 17'h04000;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk($sformatf("lock_gnt_c%0d", k), 32'(c_gnt), 1);
      tick();
    end
    c_lock = 0;
    #1;
    chk("unlock_decision_gnt", 32'(c_gnt), 1);
    tick();
    chk("unlock_takeover", 32'({c_gnt, stall}), 32'b01);
    h_req = 0;
    repeat (5) tick();
    c_req = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ej32_mem_arb.md
Name: ej32_mem_arb

Overview:
- Arbiter and sequencer for the single 8-bit SRAM bus (mb8 slave, ticks on negedge clk). It shares the bus between two requesters:
  - the eJ32 core byte port (instruction fetch and load/store);
  - a host word port (TIB fill / OBUF drain by UART or loader).
- Host 32-bit words are split into 4 big-endian byte cycles.
- Core has default priority. The host gets a bounded-wait guarantee.

Parameters:
- ASZ, 17, address width (128KB).
- DSZ, 32, host word width; fixed at 4 bytes.
- MAX_WAIT, 8, max cycles a pending host request is blocked by core traffic before a forced takeover.

Ports:
- clk  in  1  system clock, posedge.
- rst_n  in  1  asynchronous active-low reset.
- c_req  in  1  core requests bus this cycle.
- c_we  in  1  core write strobe.
- c_addr  in  ASZ  core byte address.
- c_wdata  in  8  core write byte.
- c_gnt  out  1  core owns bus this cycle (combinational).
- c_rdata  out  8  read byte to core (passthrough of m_rdata).
- stall  out  1  c_req && !c_gnt; core must hold its request.
- h_req  in  1  host word request; held until h_ack.
- h_we  in  1  host write.
- h_addr  in  ASZ  byte address of MSB byte.
- h_wdata  in  DSZ  host write word.
- h_ack  out  1  one-cycle completion pulse.
- h_rdata  out  DSZ  host read word, valid with h_ack, held until next ack.
- m_addr  out  ASZ  SRAM address.
- m_we  out  1  SRAM write enable.
- m_wdata  out  8  SRAM write byte.
- m_rdata  in  8  SRAM read byte, valid before the posedge ending the cycle that presented m_addr.

Behaviour:
- Reset values: state=CORE, cnt=0, wait=0, h_ack=0, h_rdata=0. Outputs then: m_we=0, m_addr=c_addr.
- States: CORE, HOST.
- CORE state:
  - c_gnt=c_req. Bus driven by core: m_addr=c_addr, m_we=c_we&c_req, m_wdata=c_wdata.
  - Takeover at posedge if h_req && !h_ack && (!c_req || wait==MAX_WAIT). Then: state->HOST, cnt<=0.
  - When c_req=1 and wait==MAX_WAIT, c_gnt is still 1 in that decision cycle. The core is blocked starting the next cycle.
- wait counter:
  - Increments in CORE while h_req && c_req && no takeover.
  - Saturates at MAX_WAIT.
  - Cleared on takeover and on reset.
- HOST state:
  - c_gnt=0. stall=c_req.
  - m_addr = (h_addr+cnt) mod 2^ASZ (wraps at 2^ASZ-1 -> 0).
  - m_we=h_we. m_wdata = h_wdata[31-8*cnt -: 8].
  - Read: at each posedge, h_rdata[31-8*cnt -: 8] <= m_rdata.
  - cnt increments 0..3. At the posedge ending cnt==3: state->CORE, h_ack<=1.
- Latency: takeover edge E0, bytes on cycles 1..4, h_ack high in cycle 5.
  - Core is granted in cycle 5 (CORE state).
  - The takeover check masks h_req during h_ack, so an h_req still high in the ack cycle is ignored. A request held high after that cycle is a new transaction.
- HOST sequence is uninterruptible. c_req changes are ignored until return to CORE.
- h_addr, h_we and h_wdata must be stable from request until h_ack; sampled live each byte cycle.
- Reset mid-HOST aborts immediately. Bytes already written stay in SRAM, and no h_ack is issued.
- Simultaneous c_req and h_req with wait<MAX_WAIT: core wins.

Optional Feature:
- Macro: EJ32_ARB_LOCK_EN.
- When defined:
  - Adds input c_lock (1 bit), which the core asserts across multi-byte load/store sequences.
  - Takeover is suppressed while c_lock=1, even at wait==MAX_WAIT. wait stays saturated.
  - Takeover happens on the first cycle c_lock=0 and h_req=1, regardless of c_req, if wait==MAX_WAIT.
  - c_lock has no effect in HOST state.
- When undefined: port absent; behaviour as if c_lock=0.

Test Plan:
- Host write, core idle: h_req=1, h_we=1, h_addr='h1000, h_wdata='hDEADBEEF -> m_we on cycles 1..4 with addr 1000..1003 and bytes DE,AD,BE,EF; h_ack pulse in cycle 5; SRAM readback matches.
- Host read, core idle: preload 1400..1403=11,22,33,44, h_req read at 'h1400 -> h_ack in cycle 5 with h_rdata='h11223344; h_rdata holds afterward.
- Starvation bound: c_req held 1 continuously, h_req raised at cycle 0 -> takeover edge after exactly MAX_WAIT=8 blocked cycles; stall=1 for 4 cycles; core re-granted in the ack cycle.
- Wrap-around: host write at h_addr='h1FFFE -> bytes land at 1FFFE, 1FFFF, 00000, 00001.
- Reset mid-op: assert rst_n=0 at byte cnt=2 of a write -> state CORE and h_ack=0 immediately; bytes 0-1 written, 2-3 untouched; c_gnt follows c_req after release.
- (EJ32_ARB_LOCK_EN) c_lock=1 with c_req=1 and h_req=1 for 20 cycles -> no takeover, wait=8; drop c_lock -> takeover at the next edge.
